// File: rtl/pingpong_ctrl.sv
// Two-bank ping-pong buffer controller: tracks bank occupancy for a packet producer
// and sequences an output stage through IDLE/START/BUSY with a read watchdog.
module pingpong_ctrl #(
    parameter int WD_LIMIT = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_done,
    output logic        wr_bank,
    output logic        wr_ready,
    output logic        rd_start,
    output logic        rd_bank,
    input  logic        rd_done,
    output logic [1:0]  full_cnt,
    output logic        overflow,
    output logic        timeout,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [10:0] WD_LAST = 11'(WD_LIMIT - 1);

    state_t      state_q, state_d;
    logic [1:0]  bank_full_q, bank_full_d;
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [10:0] busy_cnt_q, busy_cnt_d;
    logic [1:0]  full_cnt_q, full_cnt_d;
    logic        overflow_q, overflow_d;
    logic        timeout_q, timeout_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;

    logic        wr_accept;
    logic        wr_reject;
    logic        rel_bank;

    // Acceptance is judged on the pre-edge occupancy, so a bank freed by the
    // reader at the same edge only becomes writable one cycle later.
    assign wr_ready  = ~bank_full_q[wr_bank_q];
    assign wr_accept = wr_done & wr_ready;
    assign wr_reject = wr_done & ~wr_ready;

    always_comb begin
        state_d     = state_q;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        busy_cnt_d  = busy_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        overflow_d  = 1'b0;
        timeout_d   = 1'b0;
        rel_bank    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_cnt_d = '0;
                if (bank_full_q[rd_bank_q]) state_d = START;
            end
            START: begin
                busy_cnt_d = '0;
                state_d    = BUSY;
            end
            BUSY: begin
                // A completion in the expiry cycle still counts as a normal packet.
                if (rd_done) begin
                    rel_bank  = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = IDLE;
                end else if (busy_cnt_q == WD_LAST) begin
                    rel_bank  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The reader only holds a full bank and the writer only targets an empty
        // one, so release and accept never touch the same flag.
        if (rel_bank) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
        if (wr_accept) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (wr_reject) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
        end

        full_cnt_d = {1'b0, bank_full_d[0]} + {1'b0, bank_full_d[1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            busy_cnt_q  <= '0;
            full_cnt_q  <= 2'd0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            busy_cnt_q  <= busy_cnt_d;
            full_cnt_q  <= full_cnt_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            pkt_cnt_q   <= pkt_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign rd_start = (state_q == START);
    assign full_cnt = full_cnt_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl: linear stimulus, immediate-assertion checks.
module tb_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_done;
    logic        wr_bank;
    logic        wr_ready;
    logic        rd_start;
    logic        rd_bank;
    logic        rd_done;
    logic [1:0]  full_cnt;
    logic        overflow;
    logic        timeout;
    logic [15:0] pkt_cnt;
    logic [7:0]  ovf_cnt;

    int tests  = 0;
    int failed = 0;
    int n;

    pingpong_ctrl #(.WD_LIMIT(2047)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_done  (wr_done),
        .wr_bank  (wr_bank),
        .wr_ready (wr_ready),
        .rd_start (rd_start),
        .rd_bank  (rd_bank),
        .rd_done  (rd_done),
        .full_cnt (full_cnt),
        .overflow (overflow),
        .timeout  (timeout),
        .pkt_cnt  (pkt_cnt),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_rd_start"}, 32'(rd_start), 32'd0);
        check({tag, "_full_cnt"}, 32'(full_cnt), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_timeout"},  32'(timeout),  32'd0);
        check({tag, "_pkt_cnt"},  32'(pkt_cnt),  32'd0);
        check({tag, "_ovf_cnt"},  32'(ovf_cnt),  32'd0);
        check({tag, "_wr_bank"},  32'(wr_bank),  32'd0);
        check({tag, "_rd_bank"},  32'(rd_bank),  32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        wr_done = 1'b0;
        rd_done = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // Single write into empty system; rd_start follows one edge later.
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("w1_wr_bank",  32'(wr_bank),  32'd1);
        check("w1_full_cnt", 32'(full_cnt), 32'd1);
        check("w1_rd_start", 32'(rd_start), 32'd0);
        check("w1_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        check("w1_rd_start_pulse", 32'(rd_start), 32'd1);
        check("w1_rd_bank",        32'(rd_bank),  32'd0);
        tick();
        check("w1_rd_start_end",   32'(rd_start), 32'd0);

        // Second write fills both banks; third overflows.
        wr_done = 1'b1;
        tick();
        check("w2_full_cnt", 32'(full_cnt), 32'd2);
        check("w2_wr_ready", 32'(wr_ready), 32'd0);
        check("w2_wr_bank",  32'(wr_bank),  32'd0);
        tick();
        wr_done = 1'b0;
        check("w3_overflow", 32'(overflow), 32'd1);
        check("w3_ovf_cnt",  32'(ovf_cnt),  32'd1);
        check("w3_full_cnt", 32'(full_cnt), 32'd2);
        check("w3_wr_bank",  32'(wr_bank),  32'd0);
        tick();
        check("w3_overflow_end", 32'(overflow), 32'd0);

        // Normal completion 1504 cycles after rd_start.
        repeat (1499) tick();
        check("rd1_no_timeout", 32'(timeout), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("rd1_pkt_cnt",  32'(pkt_cnt),  32'd1);
        check("rd1_rd_bank",  32'(rd_bank),  32'd1);
        check("rd1_full_cnt", 32'(full_cnt), 32'd1);
        check("rd1_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        check("rd2_rd_start", 32'(rd_start), 32'd1);
        check("rd2_rd_bank",  32'(rd_bank),  32'd1);

        // No rd_done: watchdog fires 2048 edges after the rd_start sample.
        n = 0;
        while (!timeout && n < 3000) begin
            tick();
            n++;
        end
        check("wd_latency",  32'(n),        32'd2048);
        check("wd_timeout",  32'(timeout),  32'd1);
        check("wd_pkt_cnt",  32'(pkt_cnt),  32'd1);
        check("wd_full_cnt", 32'(full_cnt), 32'd0);
        check("wd_rd_bank",  32'(rd_bank),  32'd0);
        tick();
        check("wd_timeout_end", 32'(timeout),  32'd0);
        check("wd_idle",        32'(rd_start), 32'd0);

        // Fill both banks with the reader busy on bank 0.
        wr_done = 1'b1;
        tick();
        tick();
        wr_done = 1'b0;
        tick();
        check("sim_pre_full",  32'(full_cnt), 32'd2);
        check("sim_pre_ready", 32'(wr_ready), 32'd0);

        // Simultaneous write and completion: write rejected on pre-edge state.
        wr_done = 1'b1;
        rd_done = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
        check("sim_overflow", 32'(overflow), 32'd1);
        check("sim_full_cnt", 32'(full_cnt), 32'd1);
        check("sim_wr_ready", 32'(wr_ready), 32'd1);
        check("sim_pkt_cnt",  32'(pkt_cnt),  32'd2);
        check("sim_ovf_cnt",  32'(ovf_cnt),  32'd2);
        check("sim_wr_bank",  32'(wr_bank),  32'd0);
        tick();
        check("sim_rd_start", 32'(rd_start), 32'd1);
        check("sim_rd_bank",  32'(rd_bank),  32'd1);

        // rd_done during START is ignored.
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("start_rd_pkt",  32'(pkt_cnt),  32'd2);
        check("start_rd_bank", 32'(rd_bank),  32'd1);
        check("start_rd_full", 32'(full_cnt), 32'd1);

        // Reset mid-BUSY, then a stray rd_done.
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("busy_rst");
        reset = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("stray_pkt_cnt",  32'(pkt_cnt),  32'd0);
        check("stray_full_cnt", 32'(full_cnt), 32'd0);
        check("stray_rd_bank",  32'(rd_bank),  32'd0);
        check("stray_rd_start", 32'(rd_start), 32'd0);
        check("stray_timeout",  32'(timeout),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
